// File: rtl/quad_decoder_if.sv
// Bus bundle for the quadrature decoder: raw encoder pins and control in,
// counter-facing strobes and the sticky error flag out.
interface quad_decoder_if #(
    parameter int WIDTH = 8
);
    logic             a_in;
    logic             b_in;
    logic             idx_in;
    logic [WIDTH-1:0] idx_val;
    logic             err_clr;
    logic             en_out;
    logic             ud_out;
    logic             load_out;
    logic [WIDTH-1:0] d_out;
    logic             err_out;

    modport master (
        output a_in, b_in, idx_in, idx_val, err_clr,
        input  en_out, ud_out, load_out, d_out, err_out
    );

    modport slave (
        input  a_in, b_in, idx_in, idx_val, err_clr,
        output en_out, ud_out, load_out, d_out, err_out
    );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature encoder front-end: synchronise and glitch-filter A/B/index, decode
// the Gray sequence into en/ud step strobes plus an index-driven preset load.
module quad_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int WIDTH       = 8
) (
    input  logic           ck,
    input  logic           reset,
    quad_decoder_if.slave  bus
);
    localparam int CW = $clog2(FILT_LEN + 1);

    typedef enum logic [2:0] {INIT, S00, S10, S11, S01} stateType;

    logic [2:0]    pinRaw;
    logic [2:0]    filt;
    logic [2:0]    filtPrev;
    stateType      state;
    stateType      nextState;
    stateType      newState;
    logic [CW-1:0] initCnt;
    logic          idxRise;
    logic [1:0]    posDelta;
    logic          stepNext, upNext, loadNext, errNext;
    logic          stepReg, upReg, loadReg, errReg;

    // Bit 0 is A, bit 1 is B, bit 2 is index.
    assign pinRaw = {bus.idx_in, bus.b_in, bus.a_in};

    // A level is accepted only after it has differed from the filtered level
    // for FILT_LEN consecutive cycles; any agreement restarts the count.
    for (genvar p = 0; p < 3; p++) begin : g_pin
        logic [SYNC_STAGES-1:0] chain;
        logic [CW-1:0]          cnt;
        logic                   lvl;

        always_ff @(posedge ck or negedge reset) begin
            if (!reset) begin
                chain <= '0;
                cnt   <= '0;
                lvl   <= 1'b0;
            end else begin
                chain <= {chain[SYNC_STAGES-2:0], pinRaw[p]};
                if (chain[SYNC_STAGES-1] == lvl) begin
                    cnt <= '0;
                end else if (cnt == CW'(FILT_LEN - 1)) begin
                    lvl <= chain[SYNC_STAGES-1];
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign filt[p] = lvl;
    end

    function automatic stateType abToState(input logic a, input logic b);
        case ({a, b})
            2'b00:   return S00;
            2'b10:   return S10;
            2'b11:   return S11;
            default: return S01;
        endcase
    endfunction

    function automatic logic [1:0] grayPos(input stateType s);
        case (s)
            S10:     return 2'd1;
            S11:     return 2'd2;
            S01:     return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            state    <= INIT;
            filtPrev <= '0;
            initCnt  <= '0;
            stepReg  <= 1'b0;
            upReg    <= 1'b0;
            loadReg  <= 1'b0;
            errReg   <= 1'b0;
        end else begin
            state    <= nextState;
            filtPrev <= filt;
            initCnt  <= (state == INIT) ? initCnt + 1'b1 : '0;
            stepReg  <= stepNext;
            upReg    <= upNext;
            loadReg  <= loadNext;
            errReg   <= errNext;
        end
    end

    // A position delta of 1 is an up step, 3 is down, 2 means both pins moved.
    // An index load in the same cycle suppresses the step but not the state move.
    always_comb begin
        nextState = state;
        stepNext  = 1'b0;
        upNext    = 1'b0;
        loadNext  = 1'b0;
        errNext   = 1'b0;
        newState  = abToState(filt[0], filt[1]);
        idxRise   = filt[2] & ~filtPrev[2];
        posDelta  = grayPos(newState) - grayPos(state);
        if (state == INIT) begin
            if ((filt != filtPrev) || (initCnt == CW'(FILT_LEN - 1))) begin
                nextState = newState;
            end
        end else begin
            loadNext = idxRise;
            if (newState != state) begin
                nextState = newState;
                if (posDelta == 2'd2) begin
                    errNext = 1'b1;
                end else if (!idxRise) begin
                    stepNext = 1'b1;
                    upNext   = (posDelta == 2'd1);
                end
            end
        end
    end

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            bus.en_out   <= 1'b0;
            bus.ud_out   <= 1'b0;
            bus.load_out <= 1'b0;
            bus.d_out    <= '0;
            bus.err_out  <= 1'b0;
        end else begin
            bus.en_out   <= stepReg | loadReg;
            bus.load_out <= loadReg;
            bus.d_out    <= loadReg ? bus.idx_val : '0;
            if (stepReg) begin
                bus.ud_out <= upReg;
            end
            if (errReg) begin
                bus.err_out <= 1'b1;
            end else if (bus.err_clr) begin
                bus.err_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: reset, forward/reverse stepping, glitch
// rejection, illegal transitions, index load and load/step coincidence.
module tb_quad_decoder;
    logic ck;
    logic reset;
    int   totalCount = 0;
    int   badCount   = 0;

    quad_decoder_if #(.WIDTH(8)) bus ();

    quad_decoder #(
        .SYNC_STAGES(2),
        .FILT_LEN   (4),
        .WIDTH      (8)
    ) dut (
        .ck   (ck),
        .reset(reset),
        .bus  (bus)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Drive the pins right after a falling edge, then observe for a fixed window.
    // enFirst is the falling-edge index (1-based) of the first en_out pulse.
    task automatic applyStimulus(input logic a, input logic b, input logic idx, input int cycles,
                                 output int enCnt, output int upCnt, output int loadCnt,
                                 output int enFirst, output logic [7:0] dSeen);
        enCnt   = 0;
        upCnt   = 0;
        loadCnt = 0;
        enFirst = 0;
        dSeen   = 8'h00;
        bus.a_in   = a;
        bus.b_in   = b;
        bus.idx_in = idx;
        for (int k = 1; k <= cycles; k++) begin
            @(negedge ck);
            if (bus.en_out) begin
                enCnt++;
                if (enFirst == 0) enFirst = k;
                if (bus.load_out) begin
                    loadCnt++;
                    dSeen = bus.d_out;
                end else if (bus.ud_out) begin
                    upCnt++;
                end
            end
        end
    endtask

    task automatic test_reset();
        int en, up, ld, first;
        logic [7:0] d;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge ck);
            bus.a_in   = 1'($urandom_range(0, 1));
            bus.b_in   = 1'($urandom_range(0, 1));
            bus.idx_in = 1'($urandom_range(0, 1));
        end
        @(negedge ck);
        totalCount++;
        if ({bus.en_out, bus.ud_out, bus.load_out, bus.err_out} !== 4'b0000) begin
            badCount++;
            $display("[TB] FAIL reset_flags: got %b want 0000", {bus.en_out, bus.ud_out, bus.load_out, bus.err_out});
        end
        totalCount++;
        if (bus.d_out !== 8'h00) begin
            badCount++;
            $display("[TB] FAIL reset_d: got %h want 00", bus.d_out);
        end
        bus.a_in   = 1'b0;
        bus.b_in   = 1'b0;
        bus.idx_in = 1'b0;
        @(negedge ck);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 20, en, up, ld, first, d);
        totalCount++;
        if (en !== 0) begin
            badCount++;
            $display("[TB] FAIL release_en: got %0d pulses want 0", en);
        end
        totalCount++;
        if (bus.err_out !== 1'b0) begin
            badCount++;
            $display("[TB] FAIL release_err: got %b want 0", bus.err_out);
        end
    endtask

    task automatic test_forward();
        logic [1:0] seq [4];
        int en, up, ld, first;
        logic [7:0] d;
        seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        for (int s = 0; s < 4; s++) begin
            applyStimulus(seq[s][1], seq[s][0], 1'b0, 10, en, up, ld, first, d);
            totalCount++;
            if (en !== 1 || up !== 1) begin
                badCount++;
                $display("[TB] FAIL fwd_step%0d: got en=%0d up=%0d want en=1 up=1", s, en, up);
            end
            totalCount++;
            if (first !== 8) begin
                badCount++;
                $display("[TB] FAIL fwd_latency%0d: got %0d want 8", s, first);
            end
        end
        totalCount++;
        if (bus.err_out !== 1'b0) begin
            badCount++;
            $display("[TB] FAIL fwd_err: got %b want 0", bus.err_out);
        end
    endtask

    task automatic test_reverse();
        logic [1:0] seq [4];
        int en, up, ld, first;
        logic [7:0] d;
        seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        for (int s = 0; s < 4; s++) begin
            applyStimulus(seq[s][1], seq[s][0], 1'b0, 10, en, up, ld, first, d);
            totalCount++;
            if (en !== 1 || up !== 0 || ld !== 0) begin
                badCount++;
                $display("[TB] FAIL rev_step%0d: got en=%0d up=%0d load=%0d want en=1 up=0 load=0", s, en, up, ld);
            end
            totalCount++;
            if (first !== 8) begin
                badCount++;
                $display("[TB] FAIL rev_latency%0d: got %0d want 8", s, first);
            end
        end
        totalCount++;
        if (bus.err_out !== 1'b0) begin
            badCount++;
            $display("[TB] FAIL rev_err: got %b want 0", bus.err_out);
        end
    endtask

    task automatic test_glitch();
        int en1, up1, ld1, f1, en2, up2, ld2, f2;
        logic [7:0] d;
        applyStimulus(1'b1, 1'b0, 1'b0, 3, en1, up1, ld1, f1, d);
        applyStimulus(1'b0, 1'b0, 1'b0, 20, en2, up2, ld2, f2, d);
        totalCount++;
        if (en1 + en2 !== 0) begin
            badCount++;
            $display("[TB] FAIL glitch3: got %0d pulses want 0", en1 + en2);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 4, en1, up1, ld1, f1, d);
        applyStimulus(1'b0, 1'b0, 1'b0, 20, en2, up2, ld2, f2, d);
        totalCount++;
        if (en1 + en2 !== 2 || up1 + up2 !== 1) begin
            badCount++;
            $display("[TB] FAIL pulse4: got en=%0d up=%0d want en=2 up=1", en1 + en2, up1 + up2);
        end
    endtask

    task automatic test_illegal();
        int en, up, ld, first;
        logic [7:0] d;
        applyStimulus(1'b1, 1'b1, 1'b0, 15, en, up, ld, first, d);
        totalCount++;
        if (en !== 0) begin
            badCount++;
            $display("[TB] FAIL illegal_en: got %0d pulses want 0", en);
        end
        totalCount++;
        if (bus.err_out !== 1'b1) begin
            badCount++;
            $display("[TB] FAIL illegal_err: got %b want 1", bus.err_out);
        end
        bus.err_clr = 1'b1;
        @(negedge ck);
        bus.err_clr = 1'b0;
        totalCount++;
        if (bus.err_out !== 1'b0) begin
            badCount++;
            $display("[TB] FAIL err_clear: got %b want 0", bus.err_out);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 10, en, up, ld, first, d);
        totalCount++;
        if (en !== 1 || up !== 1) begin
            badCount++;
            $display("[TB] FAIL after_illegal_11_01: got en=%0d up=%0d want 1 1", en, up);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 10, en, up, ld, first, d);
        totalCount++;
        if (en !== 1 || up !== 1 || bus.err_out !== 1'b0) begin
            badCount++;
            $display("[TB] FAIL after_illegal_01_00: got en=%0d up=%0d err=%b want 1 1 0", en, up, bus.err_out);
        end
    endtask

    task automatic test_index();
        int en, up, ld, first;
        logic [7:0] d;
        bus.idx_val = 8'h80;
        applyStimulus(1'b0, 1'b0, 1'b1, 12, en, up, ld, first, d);
        totalCount++;
        if (en !== 1 || ld !== 1) begin
            badCount++;
            $display("[TB] FAIL index_load: got en=%0d load=%0d want 1 1", en, ld);
        end
        totalCount++;
        if (d !== 8'h80) begin
            badCount++;
            $display("[TB] FAIL index_d: got %h want 80", d);
        end
        totalCount++;
        if (bus.d_out !== 8'h00 || bus.load_out !== 1'b0) begin
            badCount++;
            $display("[TB] FAIL index_after: got d=%h load=%b want 00 0", bus.d_out, bus.load_out);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 12, en, up, ld, first, d);
        totalCount++;
        if (en !== 0) begin
            badCount++;
            $display("[TB] FAIL index_fall: got %0d pulses want 0", en);
        end
    endtask

    task automatic test_coincident();
        int en, up, ld, first;
        logic [7:0] d;
        bus.idx_val = 8'h5a;
        applyStimulus(1'b1, 1'b0, 1'b1, 15, en, up, ld, first, d);
        totalCount++;
        if (en !== 1 || ld !== 1 || d !== 8'h5a) begin
            badCount++;
            $display("[TB] FAIL coincident: got en=%0d load=%0d d=%h want 1 1 5a", en, ld, d);
        end
        // The FSM must have moved to S10, so 10->11 is a legal up step.
        applyStimulus(1'b1, 1'b1, 1'b1, 12, en, up, ld, first, d);
        totalCount++;
        if (en !== 1 || up !== 1 || bus.err_out !== 1'b0) begin
            badCount++;
            $display("[TB] FAIL coincident_next: got en=%0d up=%0d err=%b want 1 1 0", en, up, bus.err_out);
        end
    endtask

    initial begin
        reset       = 1'b0;
        bus.a_in    = 1'b0;
        bus.b_in    = 1'b0;
        bus.idx_in  = 1'b0;
        bus.idx_val = 8'h00;
        bus.err_clr = 1'b0;
        test_reset();
        test_forward();
        test_reverse();
        test_glitch();
        test_illegal();
        test_index();
        test_coincident();
        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end
endmodule
